// File: rtl/direction_flag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : maze_pkg
// Purpose  : Playfield geometry, constant maze tile map, direction encoding
//            and the tile wall lookup shared by the direction_flag block.
// Revision : 1.0 - initial release
// ============================================================================
package maze_pkg;

    localparam int TILE_SIZE = 8;
    localparam int MAP_W     = 40;
    localparam int MAP_H     = 30;

    localparam int c_TILE_SHIFT = $clog2(TILE_SIZE);
    localparam int c_ROW_W      = $clog2(MAP_H);
    localparam int c_COL_W      = $clog2(MAP_W);
    localparam int c_COORD_W    = 10;

    localparam logic [3:0] c_DIR_L = 4'b1000;
    localparam logic [3:0] c_DIR_U = 4'b0100;
    localparam logic [3:0] c_DIR_R = 4'b0010;
    localparam logic [3:0] c_DIR_D = 4'b0001;

    typedef logic signed [c_COORD_W-1:0] coord_t;

    // AXIS_COL: the probed strip is a set of columns, the span runs over rows.
    typedef enum logic {
        AXIS_COL = 1'b0,
        AXIS_ROW = 1'b1
    } axis_e;

    // Row patterns; leftmost literal bit is tile column 0.
    localparam logic [0:MAP_W-1] c_ROW_W_ALL = 40'b1111111111_1111111111_1111111111_1111111111;
    localparam logic [0:MAP_W-1] c_ROW_OPEN  = 40'b1000000000_0000000000_0000000000_0000000001;
    localparam logic [0:MAP_W-1] c_ROW_BARS  = 40'b1001111001_1111100111_1110011111_1001111001;
    localparam logic [0:MAP_W-1] c_ROW_PILL  = 40'b1000001000_0010000001_1000000100_0001000001;

    localparam logic [0:MAP_W-1] MAZE [0:MAP_H-1] = '{
        c_ROW_W_ALL,                                    // 0
        c_ROW_OPEN,  c_ROW_OPEN,  c_ROW_OPEN,           // 1..3
        c_ROW_BARS,  c_ROW_BARS,  c_ROW_OPEN,  c_ROW_OPEN, // 4..7
        c_ROW_PILL,  c_ROW_PILL,  c_ROW_PILL,           // 8..10
        c_ROW_OPEN,  c_ROW_OPEN,  c_ROW_BARS,  c_ROW_BARS, // 11..14
        c_ROW_OPEN,  c_ROW_OPEN,                        // 15..16
        c_ROW_PILL,  c_ROW_PILL,  c_ROW_PILL,           // 17..19
        c_ROW_OPEN,  c_ROW_OPEN,  c_ROW_BARS,  c_ROW_BARS, // 20..23
        c_ROW_OPEN,  c_ROW_OPEN,  c_ROW_OPEN,           // 24..26
        c_ROW_BARS,  c_ROW_OPEN,                        // 27..28
        c_ROW_W_ALL                                     // 29
    };

    // Tiles outside the map (including negative indices) read as wall.
    function automatic logic tile_wall(input coord_t row, input coord_t col);
        if (row < 0 || row >= coord_t'(MAP_H) || col < 0 || col >= coord_t'(MAP_W))
            return 1'b1;
        return MAZE[row[c_ROW_W-1:0]][col[c_COL_W-1:0]];
    endfunction

endpackage
`default_nettype wire

// File: rtl/direction_flag_if.sv
`default_nettype none
// ============================================================================
// Module   : direction_flag_if
// Purpose  : Sprite position in, per-direction free-distance flags out.
// Revision : 1.0 - initial release
// ============================================================================
interface direction_flag_if;

    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] flag_L;
    logic [2:0] flag_U;
    logic [2:0] flag_R;
    logic [2:0] flag_D;

    modport master (
        output x,
        output y,
        input  flag_L,
        input  flag_U,
        input  flag_R,
        input  flag_D
    );

    modport slave (
        input  x,
        input  y,
        output flag_L,
        output flag_U,
        output flag_R,
        output flag_D
    );

endinterface
`default_nettype wire

// File: rtl/direction_flag_edge_probe.sv
`default_nettype none
// ============================================================================
// Module   : edge_probe
// Purpose  : Free pixels (saturated at 7) in a strip next to one sprite edge,
//            resolved at tile granularity. DIRECTION_FLAG_BINARY_EN reduces
//            the result to a 1-pixel move-allowed bit.
// Revision : 1.0 - initial release
// ============================================================================
module edge_probe
    import maze_pkg::*;
#(
    parameter int SPAN = 16
) (
    input  coord_t     i_strip_start,
    input  coord_t     i_span_start,
    input  axis_e      i_axis,
    input  logic       i_backward,
    output logic [2:0] o_dist
);

    // Worst-case number of tiles touched by a SPAN-pixel edge.
    localparam int     c_SPAN_TILES = (SPAN + TILE_SIZE - 2) / TILE_SIZE + 1;
    localparam coord_t c_SPAN_M1    = coord_t'(SPAN - 1);

    coord_t w_span_first;
    coord_t w_span_last;
    coord_t w_tile0;
    logic   w_free0;

    assign w_span_first = i_span_start >>> c_TILE_SHIFT;
    assign w_span_last  = (i_span_start + c_SPAN_M1) >>> c_TILE_SHIFT;
    assign w_tile0      = i_strip_start >>> c_TILE_SHIFT;

    function automatic logic tile_free(input coord_t strip_tile, input coord_t sp_first,
                                       input coord_t sp_last, input axis_e ax);
        logic   free;
        coord_t sp;
        free = 1'b1;
        for (int k = 0; k < c_SPAN_TILES; k++) begin
            sp = sp_first + coord_t'(k);
            if (sp <= sp_last) begin
                if (ax == AXIS_COL)
                    free = free & ~tile_wall(sp, strip_tile);
                else
                    free = free & ~tile_wall(strip_tile, sp);
            end
        end
        return free;
    endfunction

    assign w_free0 = tile_free(w_tile0, w_span_first, w_span_last, i_axis);

`ifdef DIRECTION_FLAG_BINARY_EN

    assign o_dist = {2'b00, w_free0};

`else

    localparam logic [c_TILE_SHIFT:0] c_TILE = (c_TILE_SHIFT+1)'(TILE_SIZE);
    localparam logic [c_TILE_SHIFT:0] c_SAT  = (c_TILE_SHIFT+1)'(7);

    logic [c_TILE_SHIFT:0]   w_offset;
    logic [c_TILE_SHIFT:0]   w_run0;
    coord_t                  w_tile1;
    logic                    w_free1;

    assign w_offset = {1'b0, i_strip_start[c_TILE_SHIFT-1:0]};
    // Pixels of the strip that fall inside the first tile (1..TILE_SIZE).
    assign w_run0   = i_backward ? (w_offset + 1'b1) : (c_TILE - w_offset);
    assign w_tile1  = i_backward ? (w_tile0 - coord_t'(1)) : (w_tile0 + coord_t'(1));
    assign w_free1  = tile_free(w_tile1, w_span_first, w_span_last, i_axis);

    // A tile is at least 8 px, so a 7-px strip never reaches a third tile.
    always_comb begin
        o_dist = 3'd0;
        if (w_free0) begin
            if (w_run0 >= c_SAT || w_free1)
                o_dist = 3'd7;
            else
                o_dist = w_run0[2:0];
        end
    end

`endif

endmodule
`default_nettype wire

// File: rtl/direction_flag.sv
`default_nettype none
// ============================================================================
// Module   : direction_flag
// Purpose  : Registered per-direction free-distance flags for a square sprite
//            in the constant maze. Option macro: DIRECTION_FLAG_BINARY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module direction_flag
    import maze_pkg::*;
#(
    parameter int SPRITE_SIZE = 16
) (
    input  logic             clk,
    input  logic             rst,
    direction_flag_if.slave  bus
);

    localparam coord_t c_SPRITE = coord_t'(SPRITE_SIZE);
    localparam coord_t c_ONE    = coord_t'(1);

    coord_t     w_x;
    coord_t     w_y;
    logic [2:0] w_dist [0:3];
    logic [2:0] r_dist [0:3];

    assign w_x = coord_t'(bus.x);
    assign w_y = coord_t'(bus.y);

    // Probe i handles direction c_DIR_L >> i: L, U, R, D.
    for (genvar i = 0; i < 4; i++) begin : g_probe
        localparam logic [3:0] c_dir      = c_DIR_L >> i;
        localparam axis_e      c_axis     = (c_dir == c_DIR_L || c_dir == c_DIR_R) ? AXIS_COL : AXIS_ROW;
        localparam logic       c_backward = (c_dir == c_DIR_L || c_dir == c_DIR_U);

        coord_t w_strip;
        coord_t w_span;

        assign w_strip = (c_dir == c_DIR_L) ? (w_x - c_ONE)    :
                         (c_dir == c_DIR_R) ? (w_x + c_SPRITE) :
                         (c_dir == c_DIR_D) ? (w_y + c_SPRITE) :
                                              (w_y - c_ONE);
        assign w_span  = (c_axis == AXIS_COL) ? w_y : w_x;

        edge_probe #(
            .SPAN (SPRITE_SIZE)
        ) u_probe (
            .i_strip_start (w_strip),
            .i_span_start  (w_span),
            .i_axis        (c_axis),
            .i_backward    (c_backward),
            .o_dist        (w_dist[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_dist <= '{default: 3'd0};
        else
            r_dist <= w_dist;
    end

    assign bus.flag_L = r_dist[0];
    assign bus.flag_U = r_dist[1];
    assign bus.flag_R = r_dist[2];
    assign bus.flag_D = r_dist[3];

endmodule
`default_nettype wire

// File: tb/tb_direction_flag.sv
`default_nettype none
// ============================================================================
// Module   : tb_direction_flag
// Purpose  : Directed-vector self-checking bench for direction_flag.
// Revision : 1.0 - initial release
// ============================================================================
module tb_direction_flag;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    direction_flag_if u_if ();

    direction_flag dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    typedef struct {
        int x;
        int y;
        int l;
        int u;
        int r;
        int d;
    } vec_t;

    vec_t vecs [0:7];

    function automatic logic [2:0] exp_of(input int d);
`ifdef DIRECTION_FLAG_BINARY_EN
        return (d != 0) ? 3'd1 : 3'd0;
`else
        return 3'(d);
`endif
    endfunction

    task automatic check_val(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input int l, input int u, input int r, input int d);
        check_val({tag, ".L"}, u_if.flag_L, exp_of(l));
        check_val({tag, ".U"}, u_if.flag_U, exp_of(u));
        check_val({tag, ".R"}, u_if.flag_R, exp_of(r));
        check_val({tag, ".D"}, u_if.flag_D, exp_of(d));
    endtask

    task automatic drive(input int x, input int y);
        @(negedge clk);
        u_if.x = 9'(x);
        u_if.y = 9'(y);
    endtask

    initial begin
        vecs[0] = '{x:  8, y:   8, l: 0, u: 0, r: 7, d: 7};
        vecs[1] = '{x: 12, y:   8, l: 4, u: 0, r: 7, d: 7};
        vecs[2] = '{x:100, y:  11, l: 7, u: 3, r: 7, d: 5};
        vecs[3] = '{x:100, y:   8, l: 7, u: 0, r: 7, d: 7};
        vecs[4] = '{x:292, y:   8, l: 7, u: 0, r: 4, d: 7};
        vecs[5] = '{x:296, y:   8, l: 7, u: 0, r: 0, d: 7};
        vecs[6] = '{x: 24, y:  12, l: 7, u: 4, r: 7, d: 4};
        vecs[7] = '{x:  8, y: 224, l: 0, u: 7, r: 0, d: 0};

        rst    = 1'b1;
        u_if.x = 9'd200;
        u_if.y = 9'd100;
        @(posedge clk);
        #1;
        check_flags("reset", 0, 0, 0, 0);

        // Release reset; the new position must not show before the next edge.
        @(negedge clk);
        rst    = 1'b0;
        u_if.x = 9'd100;
        u_if.y = 9'd8;
        #1;
        check_val("pre_edge.R", u_if.flag_R, 3'd0);
        @(posedge clk);
        #1;
        check_flags("post_reset", 7, 0, 7, 7);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].x, vecs[i].y);
            @(posedge clk);
            #1;
            check_flags($sformatf("vec%0d(%0d,%0d)", i, vecs[i].x, vecs[i].y),
                        vecs[i].l, vecs[i].u, vecs[i].r, vecs[i].d);
        end

        for (int s = 0; s <= 4; s++) begin
            drive(8 + s, 8);
            @(posedge clk);
            #1;
            check_val($sformatf("step_x%0d.L", 8 + s), u_if.flag_L, exp_of(s));
        end

        // Reset wins over a valid position update.
        @(negedge clk);
        rst    = 1'b1;
        u_if.x = 9'd100;
        u_if.y = 9'd8;
        @(posedge clk);
        #1;
        check_flags("rst_prio", 0, 0, 0, 0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_flags("resume", 7, 0, 7, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
